dsp_prog_sequencer: RTL and testbench

- Sequences the one-time coefficient programming of the tulip DSP chain after reset.
- A single word stream feeds three targets in fixed order: interpolating LUT transfer function, user FIR taps, then reverb taps.
- Gates the chain enable until every target reports done.
- Sits between the register/DMA front end and the DSP top; the DSP `enable` is driven from `dsp_enable`.

---
 rtl/tulip_dsp_pkg.sv | 22 ++
 rtl/dsp_prog_sequencer_if.sv | 50 +++++
 rtl/prog_word_counter.sv | 35 +++
 rtl/dsp_prog_sequencer.sv | 147 ++++++++++++++
 tb/tb_dsp_prog_sequencer.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/tulip_dsp_pkg.sv
// Shared types and widths for the tulip DSP coefficient programming path.
package tulip_dsp_pkg;

  localparam int unsigned C_ADC_DWIDTH           = 24;
  localparam int unsigned C_USER_FILT_TAP_DWIDTH = 16;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_LUT  = 3'd1,
    S_LOAD_FIR  = 3'd2,
    S_LOAD_RVB  = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_RUN       = 3'd5,
    S_ERROR     = 3'd6
  } prog_state_t;

  // Bits needed to hold the values 0..n-1, never less than one.
  function automatic int unsigned width_for(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dsp_prog_sequencer_if.sv
// Programming stream, target ports and status of the DSP programming sequencer.
interface dsp_prog_sequencer_if;
  import tulip_dsp_pkg::*;

  logic                              start;
  logic [C_ADC_DWIDTH-1:0]           prog_din;
  logic                              prog_din_valid;
  logic                              prog_din_ready;
  logic [C_ADC_DWIDTH-1:0]           lut_prog_dout;
  logic                              lut_prog_dout_valid;
  logic                              lut_prog_dout_ready;
  logic                              lut_prog_done;
  logic [C_USER_FILT_TAP_DWIDTH-1:0] fir_prog_dout;
  logic                              fir_prog_dout_valid;
  logic                              fir_prog_dout_ready;
  logic                              fir_prog_done;
  logic [C_USER_FILT_TAP_DWIDTH-1:0] rvb_prog_dout;
  logic                              rvb_prog_dout_valid;
  logic                              rvb_prog_dout_ready;
  logic                              rvb_prog_done;
  logic                              dsp_enable;
  logic                              busy;
  logic                              error;
  logic [2:0]                        state_dbg;

  modport master (
    input  start, prog_din, prog_din_valid,
    input  lut_prog_dout_ready, lut_prog_done,
    input  fir_prog_dout_ready, fir_prog_done,
    input  rvb_prog_dout_ready, rvb_prog_done,
    output prog_din_ready,
    output lut_prog_dout, lut_prog_dout_valid,
    output fir_prog_dout, fir_prog_dout_valid,
    output rvb_prog_dout, rvb_prog_dout_valid,
    output dsp_enable, busy, error, state_dbg
  );

  modport slave (
    output start, prog_din, prog_din_valid,
    output lut_prog_dout_ready, lut_prog_done,
    output fir_prog_dout_ready, fir_prog_done,
    output rvb_prog_dout_ready, rvb_prog_done,
    input  prog_din_ready,
    input  lut_prog_dout, lut_prog_dout_valid,
    input  fir_prog_dout, fir_prog_dout_valid,
    input  rvb_prog_dout, rvb_prog_dout_valid,
    input  dsp_enable, busy, error, state_dbg
  );

endinterface

// File: rtl/prog_word_counter.sv
// Loadable word up-counter with a terminal-count flag against a supplied limit.
module prog_word_counter #(
  parameter int unsigned G_WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [G_WIDTH-1:0] load_val,
  input  logic               inc,
  input  logic [G_WIDTH-1:0] term_val,
  output logic [G_WIDTH-1:0] count,
  output logic               tc
);

  logic [G_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load)
      count_d = load_val;
    else if (inc)
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count = count_q;
  assign tc    = (count_q == term_val);

endmodule

// File: rtl/dsp_prog_sequencer.sv
// Routes the post-reset coefficient stream to LUT, FIR and reverb in order,
// then holds the DSP chain disabled until every target reports done.
module dsp_prog_sequencer
  import tulip_dsp_pkg::*;
#(
  parameter int unsigned G_LUT_AWIDTH      = 10,
  parameter int unsigned G_FIR_NUM_TAPS    = 129,
  parameter int unsigned G_REVERB_NUM_TAPS = 64,
  parameter int unsigned G_DONE_TIMEOUT    = 1024
) (
  input logic                 clk,
  input logic                 reset,
  dsp_prog_sequencer_if.master bus
);

  localparam int unsigned C_LUT_N   = 2 ** G_LUT_AWIDTH;
  localparam int unsigned C_MAX_A   = (C_LUT_N > G_FIR_NUM_TAPS) ? C_LUT_N : G_FIR_NUM_TAPS;
  localparam int unsigned C_MAX_N   = (C_MAX_A > G_REVERB_NUM_TAPS) ? C_MAX_A : G_REVERB_NUM_TAPS;
  localparam int unsigned C_CW      = width_for(C_MAX_N);
  localparam int unsigned C_TW      = width_for(G_DONE_TIMEOUT);

  prog_state_t     state_q, state_d;
  logic [C_TW-1:0] timeout_q, timeout_d;
  logic            error_q, error_d;
  logic            enable_q, enable_d;
  logic            busy_q, busy_d;

  logic            din_ready;
  logic            lut_valid, fir_valid, rvb_valid;
  logic [C_CW-1:0] term_val;
  logic [C_CW-1:0] word_count;
  logic            word_tc;
  logic            hs;
  logic            start_ok;
  logic            all_done;
  logic            cnt_load;

  // Zero-latency routing: the active target's ready closes the handshake directly.
  always_comb begin
    din_ready = 1'b0;
    lut_valid = 1'b0;
    fir_valid = 1'b0;
    rvb_valid = 1'b0;
    term_val  = '0;
    case (state_q)
      S_LOAD_LUT: begin
        lut_valid = bus.prog_din_valid;
        din_ready = bus.lut_prog_dout_ready;
        term_val  = C_CW'(C_LUT_N - 1);
      end
      S_LOAD_FIR: begin
        fir_valid = bus.prog_din_valid;
        din_ready = bus.fir_prog_dout_ready;
        term_val  = C_CW'(G_FIR_NUM_TAPS - 1);
      end
      S_LOAD_RVB: begin
        rvb_valid = bus.prog_din_valid;
        din_ready = bus.rvb_prog_dout_ready;
        term_val  = C_CW'(G_REVERB_NUM_TAPS - 1);
      end
      default: ;
    endcase
  end

  assign hs       = bus.prog_din_valid & din_ready;
  assign start_ok = bus.start & (state_q inside {S_IDLE, S_RUN, S_ERROR});
  assign all_done = bus.lut_prog_done & bus.fir_prog_done & bus.rvb_prog_done;
  assign cnt_load = start_ok | (hs & word_tc);

  prog_word_counter #(
    .G_WIDTH (C_CW)
  ) u_word_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val ('0),
    .inc      (hs),
    .term_val (term_val),
    .count    (word_count),
    .tc       (word_tc)
  );

  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    error_d   = error_q;
    case (state_q)
      S_IDLE, S_RUN, S_ERROR: begin
        if (start_ok) begin
          state_d   = S_LOAD_LUT;
          timeout_d = '0;
          error_d   = 1'b0;
        end
      end
      S_LOAD_LUT: if (hs && word_tc) state_d = S_LOAD_FIR;
      S_LOAD_FIR: if (hs && word_tc) state_d = S_LOAD_RVB;
      S_LOAD_RVB: begin
        if (hs && word_tc) begin
          state_d   = S_WAIT_DONE;
          timeout_d = '0;
        end
      end
      S_WAIT_DONE: begin
        if (all_done) begin
          state_d = S_RUN;
        end else if (timeout_q == C_TW'(G_DONE_TIMEOUT - 1)) begin
          state_d = S_ERROR;
          error_d = 1'b1;
        end else begin
          timeout_d = timeout_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    enable_d = (state_d == S_RUN);
    busy_d   = state_d inside {S_LOAD_LUT, S_LOAD_FIR, S_LOAD_RVB, S_WAIT_DONE};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      timeout_q <= '0;
      error_q   <= 1'b0;
      enable_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
      error_q   <= error_d;
      enable_q  <= enable_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.prog_din_ready      = din_ready;
  assign bus.lut_prog_dout       = bus.prog_din;
  assign bus.lut_prog_dout_valid = lut_valid;
  assign bus.fir_prog_dout       = bus.prog_din[C_USER_FILT_TAP_DWIDTH-1:0];
  assign bus.fir_prog_dout_valid = fir_valid;
  assign bus.rvb_prog_dout       = bus.prog_din[C_USER_FILT_TAP_DWIDTH-1:0];
  assign bus.rvb_prog_dout_valid = rvb_valid;
  assign bus.dsp_enable          = enable_q;
  assign bus.busy                = busy_q;
  assign bus.error               = error_q;
  assign bus.state_dbg           = state_q;

endmodule

// File: tb/tb_dsp_prog_sequencer.sv
// Directed bench for dsp_prog_sequencer with a shrunken configuration (16/5/3 words, 16-cycle timeout).
module tb_dsp_prog_sequencer;
  import tulip_dsp_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  dsp_prog_sequencer_if bus ();

  dsp_prog_sequencer #(
    .G_LUT_AWIDTH      (4),
    .G_FIR_NUM_TAPS    (5),
    .G_REVERB_NUM_TAPS (3),
    .G_DONE_TIMEOUT    (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  function automatic logic [2:0] tgt_state(input int tgt);
    return (tgt == 0) ? S_LOAD_LUT : (tgt == 1) ? S_LOAD_FIR : S_LOAD_RVB;
  endfunction

  // Present one word and hold it until accepted; checks routing on every attempt.
  task automatic send(input logic [23:0] w, input int tgt, input bit bp);
    bit   acc;
    logic exp_rdy;
    acc = 1'b0;
    bus.prog_din       = w;
    bus.prog_din_valid = 1'b1;
    for (int k = 0; k < 40 && !acc; k++) begin
      if (bp) bus.fir_prog_dout_ready = 1'($urandom_range(0, 1));
      #1;
      exp_rdy = (tgt == 0) ? bus.lut_prog_dout_ready :
                (tgt == 1) ? bus.fir_prog_dout_ready : bus.rvb_prog_dout_ready;
      chk("load_state", bus.state_dbg, tgt_state(tgt));
      chk("din_ready", bus.prog_din_ready, exp_rdy);
      chk("lut_valid", bus.lut_prog_dout_valid, tgt == 0);
      chk("fir_valid", bus.fir_prog_dout_valid, tgt == 1);
      chk("rvb_valid", bus.rvb_prog_dout_valid, tgt == 2);
      case (tgt)
        0:       chk("lut_data", bus.lut_prog_dout, w);
        1:       chk("fir_data", bus.fir_prog_dout, w[15:0]);
        default: chk("rvb_data", bus.rvb_prog_dout, w[15:0]);
      endcase
      acc = bus.prog_din_ready;
      tick();
    end
    chk("word_accepted", acc, 1);
    bus.prog_din_valid = 1'b0;
    if (bp) bus.fir_prog_dout_ready = 1'b1;
  endtask

  // Full 24-word load; optionally pulses start before word start_at.
  task automatic seq(input logic [23:0] base, input bit bp, input int start_at);
    int tgt;
    for (int i = 0; i < 24; i++) begin
      tgt = (i < 16) ? 0 : (i < 21) ? 1 : 2;
      if (i == start_at) begin
        pulse_start();
        chk("ignored_start", bus.state_dbg, tgt_state(tgt));
        chk("ignored_start_busy", bus.busy, 1);
      end
      send(24'(base + 24'(i)), tgt, bp && (tgt == 1));
    end
  endtask

  initial begin
    reset                   = 1'b1;
    bus.start               = 1'b0;
    bus.prog_din            = 24'h123456;
    bus.prog_din_valid      = 1'b1;
    bus.lut_prog_dout_ready = 1'b1;
    bus.fir_prog_dout_ready = 1'b1;
    bus.rvb_prog_dout_ready = 1'b1;
    bus.lut_prog_done       = 1'b0;
    bus.fir_prog_done       = 1'b0;
    bus.rvb_prog_done       = 1'b0;
    tick();
    tick();

    // Reset state, with a valid word already waiting
    chk("rst_state", bus.state_dbg, S_IDLE);
    chk("rst_enable", bus.dsp_enable, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_ready", bus.prog_din_ready, 0);
    chk("rst_valids", {bus.lut_prog_dout_valid, bus.fir_prog_dout_valid, bus.rvb_prog_dout_valid}, 0);
    reset = 1'b0;
    tick();
    chk("idle_state", bus.state_dbg, S_IDLE);
    chk("idle_ready", bus.prog_din_ready, 0);
    chk("idle_valids", {bus.lut_prog_dout_valid, bus.fir_prog_dout_valid, bus.rvb_prog_dout_valid}, 0);
    bus.prog_din_valid = 1'b0;

    // Normal sequence, done flags two cycles after the last word
    pulse_start();
    chk("start_state", bus.state_dbg, S_LOAD_LUT);
    chk("start_busy", bus.busy, 1);
    seq(24'h000000, 1'b0, -1);
    chk("wait_state", bus.state_dbg, S_WAIT_DONE);
    chk("wait_busy", bus.busy, 1);
    chk("wait_ready", bus.prog_din_ready, 0);
    tick();
    tick();
    bus.lut_prog_done = 1'b1;
    bus.fir_prog_done = 1'b1;
    bus.rvb_prog_done = 1'b1;
    #1;
    chk("enable_before", bus.dsp_enable, 0);
    tick();
    chk("run_enable", bus.dsp_enable, 1);
    chk("run_state", bus.state_dbg, S_RUN);
    chk("run_busy", bus.busy, 0);
    chk("run_ready", bus.prog_din_ready, 0);

    // Restart from RUN with FIR backpressure; done flags already high
    pulse_start();
    chk("restart_enable", bus.dsp_enable, 0);
    chk("restart_state", bus.state_dbg, S_LOAD_LUT);
    seq(24'hABC000, 1'b1, -1);
    chk("bp_wait_state", bus.state_dbg, S_WAIT_DONE);
    chk("bp_wait_enable", bus.dsp_enable, 0);
    tick();
    chk("bp_run_state", bus.state_dbg, S_RUN);
    chk("bp_run_enable", bus.dsp_enable, 1);

    // Timeout: reverb never reports done
    bus.rvb_prog_done = 1'b0;
    pulse_start();
    seq(24'h5A0100, 1'b0, -1);
    chk("to_wait_state", bus.state_dbg, S_WAIT_DONE);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("to_state", bus.state_dbg, (i < 16) ? S_WAIT_DONE : S_ERROR);
      chk("to_error", bus.error, i == 16);
      chk("to_enable", bus.dsp_enable, 0);
    end
    chk("err_busy", bus.busy, 0);
    tick();
    chk("err_hold_state", bus.state_dbg, S_ERROR);
    chk("err_hold_error", bus.error, 1);
    chk("err_ready", bus.prog_din_ready, 0);
    pulse_start();
    chk("err_restart_state", bus.state_dbg, S_LOAD_LUT);
    chk("err_restart_error", bus.error, 0);
    chk("err_restart_busy", bus.busy, 1);

    // Reset mid-load after LUT word 7, then a fresh full load
    bus.rvb_prog_done = 1'b1;
    for (int i = 0; i < 8; i++) send(24'(24'h300000 + 24'(i)), 0, 1'b0);
    reset              = 1'b1;
    bus.prog_din_valid = 1'b1;
    tick();
    chk("mid_rst_state", bus.state_dbg, S_IDLE);
    chk("mid_rst_ready", bus.prog_din_ready, 0);
    chk("mid_rst_valids", {bus.lut_prog_dout_valid, bus.fir_prog_dout_valid, bus.rvb_prog_dout_valid}, 0);
    chk("mid_rst_busy", bus.busy, 0);
    reset              = 1'b0;
    bus.prog_din_valid = 1'b0;
    pulse_start();
    seq(24'h010203, 1'b0, -1);
    chk("rl_wait_state", bus.state_dbg, S_WAIT_DONE);
    tick();
    chk("rl_run_enable", bus.dsp_enable, 1);

    // Start ignored during FIR load, then a 25th word must stall
    pulse_start();
    chk("ig_enable", bus.dsp_enable, 0);
    seq(24'hFFFF00, 1'b0, 18);
    bus.prog_din       = 24'hFFFF18;
    bus.prog_din_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("extra_ready", bus.prog_din_ready, 0);
      chk("extra_valids", {bus.lut_prog_dout_valid, bus.fir_prog_dout_valid, bus.rvb_prog_dout_valid}, 0);
      tick();
    end
    chk("extra_state", bus.state_dbg, S_RUN);
    chk("extra_enable", bus.dsp_enable, 1);
    bus.prog_din_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
